inst_fetch: RTL and testbench

Instruction fetch unit: the requesting side of the combinational instruction memory port. It owns the program counter, drives the fetch address, and captures the returned instruction word into an IF/ID output register. The output register uses a valid/ready handshake toward decode. Branch redirects squash the fetch in flight, and the unit halts when the PC runs past the end of the loaded program.

---
 rtl/inst_fetch.sv | 69 ++++++
 tb/tb_inst_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, drives the combinational imem port and
// holds the fetched word in an IF/ID register handed to decode via valid/ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0004,
  parameter logic [31:0] END_ADDR = 32'h0000_0024,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc_plus4,
  output logic        halted,
  output logic [15:0] fetch_count,
  output logic        misalign_err
);

  logic [31:0] pc;
  logic        handoff;
  logic        in_range;
  logic        can_fetch;

  assign imem_addr = pc;
  assign handoff   = if_valid && id_ready;
  assign in_range  = (pc <= END_ADDR);
  assign can_fetch = !stall && in_range && (!if_valid || id_ready);
  assign halted    = !in_range && !if_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      if_valid     <= 1'b0;
      if_pc        <= '0;
      if_pc_plus4  <= '0;
      if_inst      <= NOP_INST;
      fetch_count  <= '0;
      misalign_err <= 1'b0;
    end else begin
      // A handoff completing on a redirect edge still counts.
      if (handoff && (fetch_count != 16'hFFFF))
        fetch_count <= fetch_count + 16'd1;

      if (redirect) begin
        pc       <= {redirect_pc[31:2], 2'b00};
        if_valid <= 1'b0;
        if_inst  <= NOP_INST;
        if (redirect_pc[1:0] != 2'b00)
          misalign_err <= 1'b1;
      end else if (can_fetch) begin
        if_inst     <= imem_inst;
        if_pc       <= pc;
        if_pc_plus4 <= pc + 32'd4;
        if_valid    <= 1'b1;
        pc          <= pc + 32'd4;
      end else if (handoff) begin
        if_valid <= 1'b0;
        if_inst  <= NOP_INST;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, straight-line run to halt, backpressure,
// redirects (aligned, misaligned, beyond end), stall drain and async reset.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_pc_plus4;
  logic        halted;
  logic [15:0] fetch_count;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_pc_plus4(if_pc_plus4), .halted(halted), .fetch_count(fetch_count),
    .misalign_err(misalign_err)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h04:  rom = 32'h0010_0293;
      32'h08:  rom = 32'h0030_0313;
      32'h0C:  rom = 32'h0062_B223;
      32'h10:  rom = 32'h0002_A383;
      32'h14:  rom = 32'h0073_0433;
      32'h18:  rom = 32'h0083_2023;
      32'h1C:  rom = 32'h0000_0463;
      32'h20:  rom = 32'h0062_82B3;
      32'h24:  rom = 32'h4053_83B3;
      default: rom = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign imem_inst = rom(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_inst", if_inst, NOP);
    check("rst_pc", if_pc, 32'd0);
    check("rst_pc4", if_pc_plus4, 32'd0);
    check("rst_cnt", {16'd0, fetch_count}, 32'd0);
    check("rst_mis", {31'd0, misalign_err}, 32'd0);
    check("rst_addr", imem_addr, 32'h4);
    check("rst_halt", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;

    // Straight run to halt
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("run_valid", {31'd0, if_valid}, 32'd1);
      check("run_pc", if_pc, 32'(4 * k));
      check("run_inst", if_inst, rom(32'(4 * k)));
      check("run_pc4", if_pc_plus4, 32'(4 * k + 4));
      check("run_cnt", {16'd0, fetch_count}, 32'(k - 1));
    end
    check("run_last_inst", if_inst, 32'h4053_83B3);
    tick();
    check("end_valid", {31'd0, if_valid}, 32'd0);
    check("end_inst", if_inst, NOP);
    check("end_addr", imem_addr, 32'h28);
    check("end_halt", {31'd0, halted}, 32'd1);
    check("end_cnt", {16'd0, fetch_count}, 32'd9);
    tick();
    check("end_hold_cnt", {16'd0, fetch_count}, 32'd9);

    // Backpressure at if_pc=0xC
    do_reset();
    repeat (3) tick();
    check("bp_pc0", if_pc, 32'hC);
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_pc", if_pc, 32'hC);
      check("bp_inst", if_inst, 32'h0062_B223);
      check("bp_valid", {31'd0, if_valid}, 32'd1);
      check("bp_addr", imem_addr, 32'h10);
      check("bp_cnt", {16'd0, fetch_count}, 32'd2);
    end
    id_ready = 1'b1;
    tick();
    check("bp_rel_cnt", {16'd0, fetch_count}, 32'd3);
    check("bp_rel_pc", if_pc, 32'h10);
    repeat (3) tick();
    check("pre_redir_pc", if_pc, 32'h1C);

    // Redirect during handoff of 0x1C
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    check("rd_cnt", {16'd0, fetch_count}, 32'd7);
    check("rd_valid", {31'd0, if_valid}, 32'd0);
    check("rd_inst", if_inst, NOP);
    check("rd_addr", imem_addr, 32'h20);
    tick();
    check("rd_pc", if_pc, 32'h20);
    check("rd_inst2", if_inst, 32'h0062_82B3);

    // Misaligned redirect, then sticky through an aligned one
    redirect = 1'b1; redirect_pc = 32'h12;
    tick();
    check("mis_addr", imem_addr, 32'h10);
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_cnt", {16'd0, fetch_count}, 32'd8);
    redirect_pc = 32'h8;
    tick();
    redirect = 1'b0;
    check("mis_sticky", {31'd0, misalign_err}, 32'd1);
    check("mis_addr2", imem_addr, 32'h8);
    tick();
    check("mis_pc", if_pc, 32'h8);
    check("mis_inst", if_inst, 32'h0030_0313);

    // Redirect beyond end, then back into program
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("far_halt", {31'd0, halted}, 32'd1);
    check("far_cnt", {16'd0, fetch_count}, 32'd9);
    tick();
    check("far_halt2", {31'd0, halted}, 32'd1);
    check("far_valid", {31'd0, if_valid}, 32'd0);
    check("far_addr", imem_addr, 32'h100);
    redirect = 1'b1; redirect_pc = 32'h4;
    tick();
    redirect = 1'b0;
    check("back_halt", {31'd0, halted}, 32'd0);
    check("back_addr", imem_addr, 32'h4);
    tick();
    check("back_valid", {31'd0, if_valid}, 32'd1);
    check("back_inst", if_inst, 32'h0010_0293);

    // Stall with valid output: handoff completes, then drains and holds
    stall = 1'b1;
    tick();
    check("st_cnt", {16'd0, fetch_count}, 32'd10);
    check("st_valid", {31'd0, if_valid}, 32'd0);
    check("st_inst", if_inst, NOP);
    check("st_addr", imem_addr, 32'h8);
    tick();
    check("st_hold_addr", imem_addr, 32'h8);
    check("st_hold_cnt", {16'd0, fetch_count}, 32'd10);
    stall = 1'b0;
    tick();
    check("st_rel_pc", if_pc, 32'h8);
    check("st_rel_err", {31'd0, misalign_err}, 32'd1);

    // Async reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, if_valid}, 32'd0);
    check("arst_cnt", {16'd0, fetch_count}, 32'd0);
    check("arst_err", {31'd0, misalign_err}, 32'd0);
    check("arst_addr", imem_addr, 32'h4);
    check("arst_inst", if_inst, NOP);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
